// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's instruction-fetch (I) and load/store (D) ports onto one
// synchronous-read memory port. D has priority; a starvation counter forces an I slot.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP_I = 2'd1,
        ST_RESP_D = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        grant_i_s, grant_d_s;
    logic        i_valid_s, d_valid_s;
    logic [31:0] mem_addr_s, mem_wdata_s;
    logic [3:0]  mem_we_s;

    // Arbitration, next-state and memory-port drive.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        addr_d      = addr_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_i_s   = 1'b0;
        grant_d_s   = 1'b0;
        i_valid_s   = 1'b0;
        d_valid_s   = 1'b0;
        mem_addr_s  = addr_q;
        mem_wdata_s = 32'd0;
        mem_we_s    = 4'd0;
        case (state_q)
            ST_IDLE: begin
                if (d_req && !(i_req && (starve_q == LIMIT))) begin
                    grant_d_s   = 1'b1;
                    mem_addr_s  = d_addr;
                    mem_wdata_s = d_wdata;
                    mem_we_s    = d_we;
                    addr_d      = d_addr;
                    if (d_we == 4'd0) begin
                        state_d = ST_RESP_D;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    if (!i_req) begin
                        starve_d = 4'd0;
                    end else if (starve_q >= LIMIT) begin
                        starve_d = LIMIT;
                    end else begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (i_req) begin
                    grant_i_s  = 1'b1;
                    mem_addr_s = i_addr;
                    addr_d     = i_addr;
                    state_d    = ST_RESP_I;
                    starve_d   = 4'd0;
                end else begin
                    starve_d = 4'd0;
                end
            end
            ST_RESP_I: begin
                // Data is taken straight from the RAM's registered output.
                i_valid_s = 1'b1;
                i_rdata_d = mem_rdata;
                state_d   = ST_IDLE;
                if (!i_req) begin
                    starve_d = 4'd0;
                end else begin
                    starve_d = starve_q;
                end
            end
            ST_RESP_D: begin
                d_valid_s = 1'b1;
                d_rdata_d = mem_rdata;
                state_d   = ST_IDLE;
                if (!i_req) begin
                    starve_d = 4'd0;
                end else begin
                    starve_d = starve_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, starvation counter, latched address and held read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            starve_q  <= 4'd0;
            addr_q    <= 32'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Reset masks every handshake and write strobe in the same cycle.
    assign i_gnt     = grant_i_s & ~rst;
    assign d_gnt     = grant_d_s & ~rst;
    assign i_valid   = i_valid_s & ~rst;
    assign d_valid   = d_valid_s & ~rst;
    assign mem_we    = rst ? 4'd0  : mem_we_s;
    assign mem_addr  = rst ? 32'd0 : mem_addr_s;
    assign mem_wdata = rst ? 32'd0 : mem_wdata_s;
    assign i_rdata   = i_valid ? mem_rdata : i_rdata_q;
    assign d_rdata   = d_valid ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a cycle-level
// transaction model plus a byte-lane RAM behind the memory port.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_we;
    logic        i_gnt, i_valid, d_gnt, d_valid;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    logic [31:0] ram     [512];
    logic [31:0] ref_mem [512];

    int errors = 0;
    int checks = 0;

    // Model state: pending response (0 none, 1 I, 2 D), starvation count, etc.
    int          m_p, m_s;
    logic [31:0] m_addr, m_pdata, m_hi, m_hd;
    logic        m_gi, m_gd;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] apply_write(logic [31:0] old, logic [3:0] we,
                                                logic [1:0] off, logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b] && (b + int'(off) < 4)) r[(b + int'(off)) * 8 +: 8] = wd[b * 8 +: 8];
        end
        return r;
    endfunction

    // Synchronous-read RAM with lane rotation, standing in for the RAM manager.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr[10:2]];
        if (mem_we != 4'd0)
            ram[mem_addr[10:2]] <= apply_write(ram[mem_addr[10:2]], mem_we, mem_addr[1:0], mem_wdata);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: predict, compare, advance model, move to next negedge.
    task automatic step();
        logic        egi, egd, eiv, edv;
        logic [31:0] ea, ewd, eir, edr;
        logic [3:0]  ewe;
        #1;
        egi = 1'b0; egd = 1'b0; eiv = 1'b0; edv = 1'b0;
        ewe = 4'd0; ewd = 32'd0; ea = m_addr; eir = m_hi; edr = m_hd;
        if (rst) begin
            ea = 32'd0;
        end else if (m_p == 1) begin
            eiv = 1'b1; eir = m_pdata;
        end else if (m_p == 2) begin
            edv = 1'b1; edr = m_pdata;
        end else begin
            egd = d_req && !(i_req && m_s == LIMIT);
            egi = !egd && i_req;
            if (egd) begin
                ea = d_addr; ewe = d_we; ewd = d_wdata;
            end else if (egi) begin
                ea = i_addr;
            end
        end
        check_val("i_gnt",     32'(i_gnt),   32'(egi));
        check_val("d_gnt",     32'(d_gnt),   32'(egd));
        check_val("i_valid",   32'(i_valid), 32'(eiv));
        check_val("d_valid",   32'(d_valid), 32'(edv));
        check_val("mem_we",    32'(mem_we),  32'(ewe));
        check_val("mem_addr",  mem_addr,  ea);
        check_val("mem_wdata", mem_wdata, ewd);
        check_val("i_rdata",   i_rdata,   eir);
        check_val("d_rdata",   d_rdata,   edr);
        if (rst) begin
            m_p = 0; m_s = 0; m_addr = 32'd0; m_hi = 32'd0; m_hd = 32'd0;
        end else begin
            if (m_p == 1) m_hi = m_pdata;
            if (m_p == 2) m_hd = m_pdata;
            if (m_p != 0) begin
                m_p = 0;
                if (!i_req) m_s = 0;
            end else if (egd) begin
                m_addr = d_addr;
                m_s = i_req ? ((m_s + 1 > LIMIT) ? LIMIT : m_s + 1) : 0;
                if (d_we != 4'd0) begin
                    ref_mem[d_addr[10:2]] = apply_write(ref_mem[d_addr[10:2]], d_we, d_addr[1:0], d_wdata);
                end else begin
                    m_p = 2; m_pdata = ref_mem[d_addr[10:2]];
                end
            end else if (egi) begin
                m_addr = i_addr; m_s = 0; m_p = 1; m_pdata = ref_mem[i_addr[10:2]];
            end else begin
                m_s = 0;
            end
        end
        m_gi = egi; m_gd = egd;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] pat;
        int         ng;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = 32'd0;
        d_addr = 32'd0; d_we = 4'd0; d_wdata = 32'd0;
        m_p = 0; m_s = 0; m_addr = 32'd0; m_pdata = 32'd0; m_hi = 32'd0; m_hd = 32'd0;
        m_gi = 1'b0; m_gd = 1'b0;
        for (int k = 0; k < 512; k++) begin
            ram[k] = $urandom; ref_mem[k] = ram[k];
        end
        ram[4] = 32'h0000_0013;   ref_mem[4] = 32'h0000_0013;
        ram[257] = 32'h0000_A5A5; ref_mem[257] = 32'h0000_A5A5;
        mem_rdata = 32'd0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;

        // Instruction fetch of 0x10
        i_req = 1'b1; i_addr = 32'h10;
        step();
        i_req = 1'b0;
        #1;
        check_val("t1_valid", 32'(i_valid), 32'd1);
        check_val("t1_rdata", i_rdata, 32'h0000_0013);
        step();

        // Full-word store then read back
        d_req = 1'b1; d_we = 4'hF; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        step();
        d_we = 4'h0; d_wdata = 32'd0;
        step();
        d_req = 1'b0;
        #1;
        check_val("t2_rdata", d_rdata, 32'hDEADBEEF);
        step();

        // Lever read at 1028
        d_req = 1'b1; d_addr = 32'd1028;
        step();
        d_req = 1'b0;
        #1;
        check_val("t4_addr", mem_addr, 32'd1028);
        check_val("t4_rdata", d_rdata, 32'h0000_A5A5);
        step();

        // Both ports held: D,D,D,D,I pattern
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h44; d_we = 4'h0;
        pat = 10'd0; ng = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (m_gi || m_gd) begin
                if (ng < 10) pat[ng] = m_gi;
                ng++;
            end
        end
        check_val("t3_pattern", 32'(pat), 32'(10'b10000_10000));
        i_req = 1'b0; d_req = 1'b0;
        step(); step();

        // Reset during a D response
        d_req = 1'b1; d_addr = 32'h80;
        step();
        d_req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; d_req = 1'b1; d_addr = 32'h84;
        step();
        d_req = 1'b0;
        step();

        // Misaligned byte store, then read the containing word
        d_req = 1'b1; d_we = 4'h1; d_addr = 32'h33; d_wdata = 32'h0000_00AB;
        step();
        d_we = 4'h0; d_addr = 32'h30;
        step();
        d_req = 1'b0;
        #1;
        check_val("t6_byte3", 32'(d_rdata[31:24]), 32'hAB);
        step();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (i_req && m_gi) i_req = 1'b0;
            else if (i_req && $urandom_range(15) == 0) i_req = 1'b0;
            if (!i_req && $urandom_range(1) == 1) begin
                i_req = 1'b1; i_addr = {21'd0, 9'($urandom_range(300)), 2'b00};
            end
            if (d_req && m_gd) d_req = 1'b0;
            else if (d_req && $urandom_range(15) == 0) d_req = 1'b0;
            if (!d_req && $urandom_range(1) == 1) begin
                d_req = 1'b1;
                d_wdata = $urandom;
                if ($urandom_range(1) == 1) begin
                    d_we = 4'($urandom_range(1, 15));
                    d_addr = {21'd0, 11'($urandom_range(1200))};
                end else begin
                    d_we = 4'h0;
                    d_addr = {21'd0, 9'($urandom_range(300)), 2'b00};
                end
            end
            rst = ($urandom_range(99) == 0);
            step();
        end
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
